// File: rtl/usb_cmd_parser.sv
// Pulls bytes from the usb_ft232h RX FIFO, parses 7-byte framed register writes and issues 32-bit writes.
// Optional build macro CMD_ACK_EN adds a 3-byte acknowledge written to the TX FIFO after each checked frame.
module usb_cmd_parser #(
   parameter int          USEDW_W        = 11,
   parameter int          TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic               clk_i,
   input  logic               nrst,
   output logic               rxf_rdreq_o,
   input  logic [7:0]         rxf_rddata_i,
   input  logic [USEDW_W-1:0] rxf_rdusedw_i,
   output logic               reg_wr_o,
   output logic [7:0]         reg_addr_o,
   output logic [31:0]        reg_data_o,
   output logic [15:0]        frame_cnt_o,
   output logic [7:0]         err_cnt_o,
`ifdef CMD_ACK_EN
   output logic               tx_wrreq_o,
   output logic [7:0]         tx_wrdata_o,
   input  logic               tx_wrfull_i,
`endif
   output logic               busy_o
);

   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {
      HUNT = 3'd0,
      ADDR = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      EXEC = 3'd4,
      ACK0 = 3'd5,
      ACK1 = 3'd6,
      ACK2 = 3'd7
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

   state_t        state_q, state_d;
   logic          pend_q, pend_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]    acc_q, acc_d;
   logic [7:0]    addr_sh_q, addr_sh_d;
   logic [31:0]   data_sh_q, data_sh_d;
   logic [1:0]    idx_q, idx_d;
   logic          reg_wr_q, reg_wr_d;
   logic [7:0]    reg_addr_q, reg_addr_d;
   logic [31:0]   reg_data_q, reg_data_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic          busy_q, busy_d;
`ifdef CMD_ACK_EN
   logic [7:0]    ack_st_q, ack_st_d;
`endif

   logic          in_frame_s, rx_ok_s, rd_req_s, timeout_s;

   assign in_frame_s = (state_q == ADDR) || (state_q == DATA) || (state_q == CSUM);
   assign rx_ok_s    = (state_q == HUNT) || in_frame_s;
   // Read request is gated by reset so no FIFO byte is lost while nrst is held low.
   assign rd_req_s   = nrst && !pend_q && (rxf_rdusedw_i != {USEDW_W{1'b0}}) && rx_ok_s;
   assign timeout_s  = in_frame_s && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   assign rxf_rdreq_o = rd_req_s;
   assign reg_wr_o    = reg_wr_q;
   assign reg_addr_o  = reg_addr_q;
   assign reg_data_o  = reg_data_q;
   assign frame_cnt_o = frame_cnt_q;
   assign err_cnt_o   = err_cnt_q;
   assign busy_o      = busy_q;

`ifdef CMD_ACK_EN
   logic ack_s;
   assign ack_s      = (state_q == ACK0) || (state_q == ACK1) || (state_q == ACK2);
   assign tx_wrreq_o = ack_s && !tx_wrfull_i;
   always_comb begin
      case (state_q)
         ACK0:    tx_wrdata_o = 8'h5A;
         ACK1:    tx_wrdata_o = addr_sh_q;
         ACK2:    tx_wrdata_o = ack_st_q;
         default: tx_wrdata_o = 8'h00;
      endcase
   end
`endif

   // Next-state and output logic of the frame parser.
   always_comb begin
      state_d     = state_q;
      pend_d      = rd_req_s;
      acc_d       = acc_q;
      addr_sh_d   = addr_sh_q;
      data_sh_d   = data_sh_q;
      idx_d       = idx_q;
      reg_wr_d    = 1'b0;
      reg_addr_d  = reg_addr_q;
      reg_data_d  = reg_data_q;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
`ifdef CMD_ACK_EN
      ack_st_d    = ack_st_q;
`endif
      // Idle counter only runs while waiting for the next byte of a frame.
      if (in_frame_s && !pend_q) begin
         to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
         to_cnt_d = {TO_W{1'b0}};
      end
      if (timeout_s) begin
         state_d   = HUNT;
         to_cnt_d  = {TO_W{1'b0}};
         err_cnt_d = sat_inc8(err_cnt_q);
      end else begin
         case (state_q)
            HUNT: begin
               if (pend_q && (rxf_rddata_i == SYNC_BYTE)) begin
                  state_d = ADDR;
               end else begin
                  state_d = HUNT;
               end
            end
            ADDR: begin
               if (pend_q) begin
                  addr_sh_d = rxf_rddata_i;
                  acc_d     = rxf_rddata_i;
                  idx_d     = 2'd3;
                  state_d   = DATA;
               end else begin
                  state_d = ADDR;
               end
            end
            DATA: begin
               if (pend_q) begin
                  data_sh_d = {data_sh_q[23:0], rxf_rddata_i};
                  acc_d     = acc_q ^ rxf_rddata_i;
                  idx_d     = idx_q - 2'd1;
                  if (idx_q == 2'd0) begin
                     state_d = CSUM;
                  end else begin
                     state_d = DATA;
                  end
               end else begin
                  state_d = DATA;
               end
            end
            CSUM: begin
               if (pend_q && (rxf_rddata_i == acc_q)) begin
                  state_d = EXEC;
               end else if (pend_q) begin
                  err_cnt_d = sat_inc8(err_cnt_q);
`ifdef CMD_ACK_EN
                  ack_st_d  = 8'h01;
                  state_d   = ACK0;
`else
                  state_d   = HUNT;
`endif
               end else begin
                  state_d = CSUM;
               end
            end
            EXEC: begin
               reg_wr_d    = 1'b1;
               reg_addr_d  = addr_sh_q;
               reg_data_d  = data_sh_q;
               frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef CMD_ACK_EN
               ack_st_d    = 8'h00;
               state_d     = ACK0;
`else
               state_d     = HUNT;
`endif
            end
`ifdef CMD_ACK_EN
            ACK0: begin
               if (!tx_wrfull_i) state_d = ACK1; else state_d = ACK0;
            end
            ACK1: begin
               if (!tx_wrfull_i) state_d = ACK2; else state_d = ACK1;
            end
            ACK2: begin
               if (!tx_wrfull_i) state_d = HUNT; else state_d = ACK2;
            end
`endif
            default: state_d = HUNT;
         endcase
      end
      busy_d = (state_d != HUNT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!nrst) begin
         state_q     <= HUNT;
         pend_q      <= 1'b0;
         to_cnt_q    <= {TO_W{1'b0}};
         acc_q       <= 8'h00;
         addr_sh_q   <= 8'h00;
         data_sh_q   <= 32'h0000_0000;
         idx_q       <= 2'd0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= 8'h00;
         reg_data_q  <= 32'h0000_0000;
         frame_cnt_q <= 16'h0000;
         err_cnt_q   <= 8'h00;
         busy_q      <= 1'b0;
`ifdef CMD_ACK_EN
         ack_st_q    <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         to_cnt_q    <= to_cnt_d;
         acc_q       <= acc_d;
         addr_sh_q   <= addr_sh_d;
         data_sh_q   <= data_sh_d;
         idx_q       <= idx_d;
         reg_wr_q    <= reg_wr_d;
         reg_addr_q  <= reg_addr_d;
         reg_data_q  <= reg_data_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         busy_q      <= busy_d;
`ifdef CMD_ACK_EN
         ack_st_q    <= ack_st_d;
`endif
      end
   end

endmodule
